cic_int_8_three: RTL
====================

CIC_INT_8_THREE -- requirements
Module: cic_int_8_three

Interface
REQ-001 The module SHALL have a single clock and a reset that is synchronous and active-high; ports are named clk and reset.
REQ-002 clk  input  1  system clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 x_in  input  8  signed two's-complement input sample, low rate.
REQ-005 in_valid  input  1  x_in is valid this cycle.
REQ-006 in_ready  output  1  block accepts x_in this cycle; a transfer occurs when in_valid && in_ready.
REQ-007 y_out  output  8  signed output sample, y_full[13:6] (divide by 64, truncate).
REQ-008 y_full  output  14  signed full-precision integrator-3 output.
REQ-009 out_valid  output  1  y_out and y_full hold a new high-rate sample this cycle.

Function
REQ-010 The block SHALL be a 3-stage CIC interpolator: R=8, N=3, differential delay M=1, transfer (1-z^-8)^3 / (1-z^-1)^3 over the zero-stuffed input.
REQ-011 The comb section SHALL advance only on an accepted input, in this order:
- w1 = x - x_prev
- w2 = w1 - w1_prev
- w3 = w2 - w2_prev
REQ-012 Comb widths SHALL be 9, 10 and 11 bits, sign-extended, with no saturation.
REQ-013 w3 SHALL be registered into u_reg on accept.
REQ-014 A 3-bit phase counter SHALL have states IDLE (no sample pending) and RUN (phase 0..7 of the current sample).
REQ-015 IDLE: in_ready=1, out_valid=0, integrators hold; an accept moves the block to RUN with phase=0 on the next cycle.
REQ-016 RUN: every cycle the integrators SHALL advance, out_valid SHALL be 1 the following cycle, and phase SHALL increment.
REQ-017 The integrator input SHALL be u_reg at phase 0 and 0 at phases 1..7 (zero-stuffing).
REQ-018 in_ready SHALL be 1 when phase==7 or in IDLE.
REQ-019 At phase 7, on accept, the block SHALL return to phase 0 with no gap; with no accept it SHALL go to IDLE (stall), with integrators holding state.
REQ-020 A stall SHALL only insert out_valid=0 gaps; the sequence of valid outputs SHALL be identical to the unstalled case.
REQ-021 The integrator chain SHALL be I1<=I1+u; I2<=I2+I1; I3<=I3+I2, all 14-bit modular (wrap) arithmetic, with y_full registered from I3.
REQ-022 Modular wrap SHALL be exact: the DC gain is 64, and the output range -8192..8128 fits in 14 bits.
REQ-023 Latency SHALL be fixed, and the same after every reset, from accept to the first out_valid carrying that sample's contribution.
REQ-024 in_valid when in_ready=0 SHALL be ignored (no accept, no state change).

Reset
REQ-025 Reset SHALL clear the following to 0 and force IDLE:
- comb delay registers, u_reg, I1..I3, phase
- y_out, y_full, out_valid
REQ-026 in_ready SHALL be 1 during and immediately after reset.
REQ-027 Reset asserted mid-burst SHALL discard all state; the output after release SHALL be as from power-up.
REQ-028 Reset SHALL have priority over a simultaneous accept.

Structure
REQ-029 R=8, N=3, input width 8, comb widths 9/10/11, integrator width 14 and output shift 6 SHALL be constants in the shared CIC package/header, also used by the decimator.
REQ-030 One sub-module, cic_int_stage (parameterised-width enabled accumulator), SHALL be instantiated three times; the comb stages stay inline.

Verification
REQ-031 Reset check: assert reset 3 cycles -> y_out=0, y_full=0, out_valid=0, in_ready=1.
REQ-032 DC step: x_in=64 held valid -> after transient, y_full=4096 and y_out=64 on every out_valid; x_in=127 -> 8128/127; x_in=-128 -> -8192/-128, with no wrap error.
REQ-033 Impulse: x_in=64 once, then 0s -> exactly 22 nonzero consecutive y_full values, which equal 64 times the coefficients of (1+z+...+z^7)^3 (1,3,6,10,...,48 peak,...,3,1); y_out peak = 48.
REQ-034 Stall:
- stimulus: random in_valid gaps on the DC/impulse streams
- response: valid-output sequence identical to the gapless run
- response: out_valid=0 during gaps
- response: no accept while in_ready=0
REQ-035 Reset mid-burst at phase 4 of x_in=100 -> outputs 0 and IDLE; a subsequent impulse reproduces REQ-033 exactly.
REQ-036 Throughput: continuous in_valid -> one accept every 8 cycles and out_valid continuously 1 after the first output.

Source files
------------

// File: rtl/cic_int_8_three_pkg.sv
// Shared CIC constants and types (used by both interpolator and decimator).
//   CIC_R      rate change factor
//   CIC_N      number of comb / integrator stages
//   IN_W       input sample width
//   C1_W..C3_W comb stage widths (one bit of growth per differentiator)
//   ACC_W      integrator width; modular wrap is exact since |y| <= 2^13
//   OUT_SHIFT  output scaling shift (divide by DC gain 64)
package cic_int_8_three_pkg;
  localparam int CIC_R     = 8;
  localparam int CIC_N     = 3;
  localparam int IN_W      = 8;
  localparam int C1_W      = 9;
  localparam int C2_W      = 10;
  localparam int C3_W      = 11;
  localparam int ACC_W     = 14;
  localparam int OUT_SHIFT = 6;
  localparam int OUT_W     = 8;
  localparam int PH_W      = 3;

  typedef enum logic {ST_IDLE, ST_RUN} cic_state_e;

  // Sign-extend the last comb output to integrator width.
  function automatic logic [ACC_W-1:0] sext_u(input logic [C3_W-1:0] v);
    return {{(ACC_W-C3_W){v[C3_W-1]}}, v};
  endfunction
endpackage

// File: rtl/cic_int_8_three_stage.sv
// Enabled wrap-around accumulator, one CIC integrator stage.
//   clk, reset : clock, synchronous active-high reset (clears acc)
//   en         : accumulate this cycle
//   d          : addend
//   acc        : accumulator register
module cic_int_stage #(
  parameter int W = 14
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] acc
);
  always_ff @(posedge clk) begin
    if (reset)   acc <= '0;
    else if (en) acc <= acc + d;
  end
endmodule

// File: rtl/cic_int_8_three.sv
// 3-stage CIC interpolator, R=8, M=1.
// Combs run at the input rate on each accepted sample; integrators run at
// the output rate on a zero-stuffed copy of the comb output. Between input
// samples the block parks in IDLE with integrators frozen, so input gaps
// only insert out_valid=0 cycles into the output stream.
//   clk, reset : clock, synchronous active-high reset
//   x_in       : signed input sample, in_valid/in_ready handshake
//   in_ready   : high in IDLE or on the last phase of the current sample
//   y_full     : full-precision integrator output (14b signed)
//   y_out      : y_full / 64 (truncated), 8b signed
//   out_valid  : one high-rate sample on y_full/y_out this cycle
module cic_int_8_three
  import cic_int_8_three_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic signed [IN_W-1:0]  x_in,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic signed [OUT_W-1:0] y_out,
  output logic signed [ACC_W-1:0] y_full,
  output logic                    out_valid
);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(CIC_R - 1);

  cic_state_e            state;
  logic [PH_W-1:0]       phase;
  logic                  accept, run;

  logic [IN_W-1:0]       x_prev;
  logic [C1_W-1:0]       w1, w1_prev;
  logic [C2_W-1:0]       w2, w2_prev;
  logic [C3_W-1:0]       w3, u_reg;

  // chain[0] is the stuffed integrator input, chain[k] is integrator k.
  logic [CIC_N:0][ACC_W-1:0] chain;
  logic [ACC_W-1:0]          y_next;

  assign run      = (state == ST_RUN);
  assign in_ready = reset || (state == ST_IDLE) || (phase == LAST_PH);
  assign accept   = in_valid && in_ready;

  // Comb section, each stage grows one bit.
  assign w1 = {x_in[IN_W-1], x_in}    - {x_prev[IN_W-1], x_prev};
  assign w2 = {w1[C1_W-1], w1}        - {w1_prev[C1_W-1], w1_prev};
  assign w3 = {w2[C2_W-1], w2}        - {w2_prev[C2_W-1], w2_prev};

  // Zero-stuffing: the comb output is injected only on phase 0.
  assign chain[0] = (phase == '0) ? sext_u(u_reg) : '0;

  for (genvar g = 0; g < CIC_N; g++) begin : g_int
    cic_int_stage #(.W(ACC_W)) u_stage (
      .clk   (clk),
      .reset (reset),
      .en    (run),
      .d     (chain[g]),
      .acc   (chain[g+1])
    );
  end

  // Value the last integrator takes at this edge.
  assign y_next = chain[CIC_N] + chain[CIC_N-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase     <= '0;
      x_prev    <= '0;
      w1_prev   <= '0;
      w2_prev   <= '0;
      u_reg     <= '0;
      y_full    <= '0;
      y_out     <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        x_prev  <= x_in;
        w1_prev <= w1;
        w2_prev <= w2;
        u_reg   <= w3;
      end
      out_valid <= run;
      if (run) begin
        y_full <= y_next;
        y_out  <= y_next[OUT_SHIFT +: OUT_W];
      end
      case (state)
        ST_IDLE: begin
          phase <= '0;
          if (accept) state <= ST_RUN;
        end
        ST_RUN: begin
          if (phase == LAST_PH) begin
            phase <= '0;
            if (!accept) state <= ST_IDLE;
          end else begin
            phase <= phase + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule
